// File: rtl/stream_collector.sv
// Capture buffer: collects a valid/ready word stream (optionally closed by in_last)
// and replays it in order on request, flagging the final word and pulsing dump_done.
module stream_collector #(
  parameter int BIT_WIDTH = 32,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_last,
  input  logic                 dump_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 dump_done,
  output logic [CNT_W-1:0]     count,
  output logic                 sealed
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {COLLECT, DUMP} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 sealed_q, sealed_d;
  logic                 done_q, done_d;
  logic [BIT_WIDTH-1:0] mem [DEPTH];

  logic                 accept;
  logic                 xfer;
  logic [CNT_W-1:0]     count_upd;

  assign in_ready  = (state_q == COLLECT) && !sealed_q && (count_q != CNT_W'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DUMP);
  assign xfer      = out_valid && out_ready;
  assign out_data  = mem[rd_ptr_q];
  assign out_last  = out_valid && (CNT_W'(rd_ptr_q) == count_q - CNT_W'(1));
  assign count_upd = count_q + CNT_W'(accept);

  assign count     = count_q;
  assign sealed    = sealed_q;
  assign dump_done = done_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sealed_d = sealed_q;
    done_d   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_upd;
          if (in_last) sealed_d = 1'b1;
        end
        // A word accepted alongside dump_req is part of this dump.
        if (dump_req) begin
          if (count_upd != '0) begin
            state_d  = DUMP;
            rd_ptr_d = '0;
          end else begin
            done_d   = 1'b1;
            sealed_d = 1'b0;
          end
        end
      end
      DUMP: begin
        if (xfer) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (out_last) begin
            state_d  = COLLECT;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            sealed_d = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sealed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sealed_q <= sealed_d;
      done_q   <= done_d;
    end
  end

  // Storage is never reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_stream_collector.sv
// Bench for stream_collector (BIT_WIDTH=8, DEPTH=4): vector table, corner-case
// sequences and a random run against a queue-based reference model.
module tb_stream_collector;
  localparam int BW = 8;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [BW-1:0] in_data;
  logic          dump_req;
  logic          out_valid, out_ready, out_last;
  logic [BW-1:0] out_data;
  logic          dump_done;
  logic [CW-1:0] count;
  logic          sealed;

  int total = 0;
  int bad   = 0;

  stream_collector #(.BIT_WIDTH(BW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dump_req(dump_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .dump_done(dump_done), .count(count), .sealed(sealed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          iv;
    logic [BW-1:0] d;
    logic          il;
    logic          dr;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [BW-1:0] e_od;
    logic          e_ol;
    logic          e_dd;
    logic [CW-1:0] e_cnt;
    logic          e_sl;
  } vec_t;

  vec_t          vt[$];
  logic [BW-1:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic iv, input logic [BW-1:0] d, input logic il,
                              input logic dr, input logic ordy, input logic e_ir,
                              input logic e_ov, input logic [BW-1:0] e_od, input logic e_ol,
                              input logic e_dd, input logic [CW-1:0] e_cnt, input logic e_sl);
    vec_t v;
    v.iv = iv; v.d = d; v.il = il; v.dr = dr; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol;
    v.e_dd = e_dd; v.e_cnt = e_cnt; v.e_sl = e_sl;
    return v;
  endfunction

  task automatic idle_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_dump_done"}, 32'(dump_done), 32'd0);
    chk({tag, "_count"},     32'(count),     32'd0);
    chk({tag, "_sealed"},    32'(sealed),    32'd0);
  endtask

  task automatic push(input logic [BW-1:0] d, input logic last);
    chk("push_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic drain(input int mode, input string tag);
    int k = 0;
    int c = 0;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    while (k < expq.size() && c < 100) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_out_data"},  32'(out_data),  32'(expq[k]));
      chk({tag, "_out_last"},  32'(out_last),  32'(k == expq.size() - 1));
      chk({tag, "_dump_done_low"}, 32'(dump_done), 32'd0);
      if (out_ready) k++;
      tick();
      c++;
    end
    chk({tag, "_words_drained"}, 32'(k), 32'(expq.size()));
    chk({tag, "_dump_done"},     32'(dump_done), 32'd1);
    chk({tag, "_end_valid"},     32'(out_valid), 32'd0);
    chk({tag, "_end_count"},     32'(count),     32'd0);
    chk({tag, "_end_sealed"},    32'(sealed),    32'd0);
    chk({tag, "_end_in_ready"},  32'(in_ready),  32'd1);
    out_ready = 1'b0;
    tick();
    chk({tag, "_done_single"},   32'(dump_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; dump_req = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_outputs("reset");
    rst = 1'b0;
    tick();
    idle_outputs("post_reset");

    // ---------------- vector table ----------------
    // round trip; writes attempted while sealed / during dump must be refused
    vt.push_back(mk(1, 8'h11, 0, 0, 0,  1, 0, 8'h00, 0, 0, 3'd1, 0));
    vt.push_back(mk(1, 8'h22, 0, 0, 0,  1, 0, 8'h00, 0, 0, 3'd2, 0));
    vt.push_back(mk(1, 8'h33, 1, 0, 0,  0, 0, 8'h00, 0, 0, 3'd3, 1));
    vt.push_back(mk(1, 8'h44, 0, 1, 1,  0, 1, 8'h11, 0, 0, 3'd3, 1));
    vt.push_back(mk(1, 8'h45, 0, 1, 1,  0, 1, 8'h22, 0, 0, 3'd3, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 1,  0, 1, 8'h33, 1, 0, 3'd3, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 8'h00, 0, 1, 3'd0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0,  1, 0, 8'h00, 0, 0, 3'd0, 0));
    // accept and dump_req in the same cycle, with a stall on the last word
    vt.push_back(mk(1, 8'h01, 0, 0, 0,  1, 0, 8'h00, 0, 0, 3'd1, 0));
    vt.push_back(mk(1, 8'h02, 0, 1, 0,  0, 1, 8'h01, 0, 0, 3'd2, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1,  0, 1, 8'h02, 1, 0, 3'd2, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0,  0, 1, 8'h02, 1, 0, 3'd2, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 8'h00, 0, 1, 3'd0, 0));
    // accept with in_last plus dump_req on an empty buffer
    vt.push_back(mk(1, 8'h77, 1, 1, 0,  0, 1, 8'h77, 1, 0, 3'd1, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 1,  1, 0, 8'h00, 0, 1, 3'd0, 0));
    // empty dump
    vt.push_back(mk(0, 8'h00, 0, 1, 0,  1, 0, 8'h00, 0, 1, 3'd0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0,  1, 0, 8'h00, 0, 0, 3'd0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      in_valid = vt[i].iv; in_data = vt[i].d; in_last = vt[i].il;
      dump_req = vt[i].dr; out_ready = vt[i].ordy;
      tick();
      chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vt[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      if (vt[i].e_ov) chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vt[i].e_od));
      chk($sformatf("vec%0d_out_last", i),  32'(out_last),  32'(vt[i].e_ol));
      chk($sformatf("vec%0d_dump_done", i), 32'(dump_done), 32'(vt[i].e_dd));
      chk($sformatf("vec%0d_count", i),     32'(count),     32'(vt[i].e_cnt));
      chk($sformatf("vec%0d_sealed", i),    32'(sealed),    32'(vt[i].e_sl));
    end
    in_valid = 1'b0; in_last = 1'b0; dump_req = 1'b0; out_ready = 1'b0;

    // ---------------- full stall ----------------
    begin
      int idx = 0;
      logic rdy;
      in_valid = 1'b1; in_data = 8'hA0; in_last = 1'b0;
      for (int c = 0; c < 6; c++) begin
        rdy = in_ready;
        tick();
        if (rdy) begin
          idx++;
          in_data = 8'(8'hA0 + idx);
        end
      end
      chk("full_accepted", 32'(idx), 32'd4);
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_sealed", 32'(sealed), 32'd0);
      expq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      drain(0, "full_dump");
      chk("full_a4_count", 32'(count), 32'd1);
      in_valid = 1'b0;
      expq = '{8'hA4};
      drain(0, "full_a4_dump");
    end

    // ---------------- backpressure ----------------
    push(8'hC1, 1'b0);
    push(8'hC2, 1'b0);
    push(8'hC3, 1'b1);
    expq = '{8'hC1, 8'hC2, 8'hC3};
    drain(1, "bp");

    // ---------------- reset mid-dump ----------------
    push(8'hD1, 1'b0);
    push(8'hD2, 1'b0);
    push(8'hD3, 1'b0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rstmid_pre_data", 32'(out_data), 32'h0D3);
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_count", 32'(count), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_dump_done", 32'(dump_done), 32'd0);
    #1 rst = 1'b0;
    tick();
    push(8'h55, 1'b0);
    expq = '{8'h55};
    drain(0, "rstmid_new");

    // ---------------- random run against queue model ----------------
    begin
      logic [BW-1:0] mbuf[$];
      bit  m_dumping = 0;
      bit  m_sealed  = 0;
      bit  m_done    = 0;
      int  m_rd      = 0;
      bit  e_ir;
      for (int c = 0; c < 800; c++) begin
        e_ir = !m_dumping && !m_sealed && (mbuf.size() < DP);
        chk("rnd_in_ready",  32'(in_ready),  32'(e_ir));
        chk("rnd_out_valid", 32'(out_valid), 32'(m_dumping));
        if (m_dumping) begin
          chk("rnd_out_data", 32'(out_data), 32'(mbuf[m_rd]));
          chk("rnd_out_last", 32'(out_last), 32'(m_rd == mbuf.size() - 1));
        end else begin
          chk("rnd_out_last_idle", 32'(out_last), 32'd0);
        end
        chk("rnd_dump_done", 32'(dump_done), 32'(m_done));
        chk("rnd_count",     32'(count),     32'(mbuf.size()));
        chk("rnd_sealed",    32'(sealed),    32'(m_sealed));

        in_valid  = 1'($urandom_range(0, 3) != 0);
        in_data   = 8'($urandom);
        in_last   = ($urandom_range(0, 7) == 0);
        dump_req  = ($urandom_range(0, 11) == 0);
        out_ready = 1'($urandom_range(0, 2) != 0);

        m_done = 0;
        if (!m_dumping) begin
          if (in_valid && e_ir) begin
            mbuf.push_back(in_data);
            if (in_last) m_sealed = 1;
          end
          if (dump_req) begin
            if (mbuf.size() > 0) begin
              m_dumping = 1;
              m_rd = 0;
            end else begin
              m_done = 1;
              m_sealed = 0;
            end
          end
        end else if (out_ready) begin
          if (m_rd == mbuf.size() - 1) begin
            mbuf.delete();
            m_dumping = 0;
            m_sealed = 0;
            m_done = 1;
          end else begin
            m_rd++;
          end
        end
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_collector.md
# stream_collector

Synthesizable capture buffer: the hardware end of the word-stream interface our file-based benches drive. It accepts a valid/ready stream of BIT_WIDTH-bit words, terminated by an end-of-stream marker. It holds up to DEPTH words and, on request, replays them in order on a valid/ready output stream with a last flag. It sits between a DUT's result port and the bench's dump path, so captured tensors are dumped in one burst.

## Interface
- BIT_WIDTH, 32, width of each data word
- DEPTH, 16, buffer capacity in words (power of two, ≥2)
- CNT_W, $clog2(DEPTH+1), width of count
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer offers in_data
- in_ready  output  1  collector can accept a word this cycle
- in_data  input  BIT_WIDTH  captured word
- in_last  input  1  qualifies the accepted word as end of stream
- dump_req  input  1  single-cycle request to replay the buffer
- out_valid  output  1  out_data holds a buffered word
- out_ready  input  1  consumer takes out_data
- out_data  output  BIT_WIDTH  replayed word
- out_last  output  1  out_data is the final buffered word
- dump_done  output  1  one-cycle pulse when a dump finishes
- count  output  CNT_W  number of words currently held
- sealed  output  1  in_last accepted; input closed until dump completes

## Operation
- States: COLLECT (reset state), DUMP.
- Accept means in_valid && in_ready. in_ready = (state==COLLECT) && !sealed && (count != DEPTH).
- On accept: mem[wr_ptr] <= in_data, wr_ptr++, count++. If in_last is set, sealed <= 1.
- When full without in_last, in_ready stays 0. There is no drop and no overflow; the producer stalls.
- COLLECT → DUMP when dump_req is high and count (after any same-cycle accept) > 0. Also reset rd_ptr to 0.
- dump_req with count==0 and no same-cycle accept: dump_done pulses next cycle, state stays COLLECT, sealed clears.
- dump_req in DUMP is ignored.
- DUMP: out_valid=1, out_data=mem[rd_ptr], out_last=(rd_ptr==count-1).
  - On out_valid && out_ready: rd_ptr++.
  - If out_last was set on that transfer: go to COLLECT, clear wr_ptr/rd_ptr/count/sealed, and pulse dump_done.
- count holds during DUMP and drops to 0 only on the final transfer.
- Pointers are log2(DEPTH) bits and never wrap within one collect/dump cycle, because count bounds them.

## Timing
- Reset values: in_ready=1 (empty, COLLECT; no write while rst high), out_valid=0, out_last=0, out_data=mem[0] (don't care), dump_done=0, count=0, sealed=0, state=COLLECT.
- Reset mid-dump aborts immediately. Buffer contents are discarded logically (count=0); memory is not cleared.
- Write latency: an accepted word is counted the cycle after the accept edge.
- Dump latency: dump_req sampled at edge N → out_valid=1 in the cycle after N. First word valid with no bubble.
- Throughput: one word per cycle in both directions when the handshake partner is always ready.
- out_data/out_last are stable while out_valid && !out_ready.
- Accept and dump_req in the same cycle: the word is stored and included in the dump. count and out_last use the updated count.
- Accept with in_last and dump_req in the same cycle: legal. sealed is set, then cleared at dump end.
- dump_done asserts in the cycle after the final out transfer edge. in_ready returns to 1 in that same cycle.

## Test plan
(BIT_WIDTH=8, DEPTH=4)
- Reset mid-dump: after 2 of 3 words are transferred, pulse rst → out_valid=0, count=0, in_ready=1. A new word 0x55 followed by a dump yields 0x55 alone with out_last=1.
- Basic round-trip: write 0x11, 0x22, 0x33 (last on 0x33), pulse dump_req, out_ready=1 → out 0x11, 0x22, 0x33 on consecutive cycles.
  - out_last only on 0x33; dump_done pulses once.
  - count goes 3→0; sealed goes 1→0.
- Full stall: in_valid held with 0xA0..0xA5, no last → 4 words accepted, in_ready=0 with count=4. dump_req replays 0xA0..0xA3; afterwards 0xA4 is accepted.
- Backpressure: during a dump, toggle out_ready 1,0,0,1,… → out_data holds each word while stalled, no word is duplicated or skipped, and out_last sits on the 3rd word.
- Simultaneous accept and dump_req: with 0x01 held, accept 0x02 on the same cycle as dump_req → dump returns 0x01, 0x02 with out_last on 0x02.
- Empty dump: dump_req with count=0 → dump_done pulses one cycle later, out_valid stays 0, state remains COLLECT.
